// File: rtl/ser_to_par_pkg.sv
// Shared types and width helpers for the buffered serial-to-parallel deserialiser.
package ser_to_par_pkg;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } hold_state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/ser_to_par_buffered_if.sv
// Sampler/consumer-side signal bundle for ser_to_par_buffered.
interface ser_to_par_buffered_if
    import ser_to_par_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic                      en;
    logic                      shift_en;
    logic                      clear;
    logic                      serial;
    logic                      ack;
    logic [WIDTH-1:0]          par_out;
    logic                      valid;
    logic                      overrun;
    logic [cnt_w(WIDTH)-1:0]   bit_cnt;

    modport master (
        output en, shift_en, clear, serial, ack,
        input  par_out, valid, overrun, bit_cnt
    );

    modport slave (
        input  en, shift_en, clear, serial, ack,
        output par_out, valid, overrun, bit_cnt
    );
endinterface

// File: rtl/ser_shift_core.sv
// Shift register and framed bit counter; flags the sample that completes a word
// and presents that word (including the current bit) combinationally.
module ser_shift_core
    import ser_to_par_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    sample,
    input  logic                    clear,
    input  logic                    serial,
    output logic [WIDTH-1:0]        word,
    output logic                    word_done,
    output logic [cnt_w(WIDTH)-1:0] bit_cnt
);
    localparam int                CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    if (MSB_FIRST) begin : g_msb_first
        assign sreg_d = {sreg_q[WIDTH-2:0], serial};
    end else begin : g_lsb_first
        assign sreg_d = {serial, sreg_q[WIDTH-1:1]};
    end

    assign word_done = sample && (cnt_q == LAST);
    assign word      = sreg_d;
    assign bit_cnt   = cnt_q;
    assign cnt_d     = word_done ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sreg_q <= '0;
        end else if (clear) begin
            sreg_q <= '0;
        end else if (sample) begin
            sreg_q <= sreg_d;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (sample) begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/ser_to_par_buffered.sv
// Serial-to-parallel deserialiser with a one-word holding register under a
// valid/ack handshake and a sticky overrun flag for dropped words.
module ser_to_par_buffered
    import ser_to_par_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                  MHz10,
    input  logic                  nrst,
    ser_to_par_buffered_if.slave  bus
);
    logic                    sample;
    logic [WIDTH-1:0]        word;
    logic                    word_done;
    logic [cnt_w(WIDTH)-1:0] bit_cnt;

    hold_state_t      state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             overrun_q, overrun_d;

    assign sample = bus.en & bus.shift_en;

    ser_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk       (MHz10),
        .nrst      (nrst),
        .sample    (sample),
        .clear     (bus.clear),
        .serial    (bus.serial),
        .word      (word),
        .word_done (word_done),
        .bit_cnt   (bit_cnt)
    );

    // ack only matters while a word is held; a completion into a full,
    // un-acked holder is dropped and recorded in the sticky overrun flag.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        overrun_d = overrun_q;
        if (bus.clear) begin
            state_d   = S_EMPTY;
            hold_d    = '0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (word_done) begin
                        hold_d  = word;
                        state_d = S_FULL;
                    end
                end
                S_FULL: begin
                    if (word_done && bus.ack) begin
                        hold_d = word;
                    end else if (word_done) begin
                        overrun_d = 1'b1;
                    end else if (bus.ack) begin
                        state_d = S_EMPTY;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge MHz10 or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge MHz10 or negedge nrst) begin
        if (!nrst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    always_ff @(posedge MHz10 or negedge nrst) begin
        if (!nrst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign bus.par_out = hold_q;
    assign bus.valid   = (state_q == S_FULL);
    assign bus.overrun = overrun_q;
    assign bus.bit_cnt = bit_cnt;
endmodule

// File: tb/tb_ser_to_par_buffered.sv
// Three deserialiser instances (8 LSB-first, 8 MSB-first, 12 LSB-first) share one
// stimulus stream and are compared every cycle against a word-level model.
module tb_ser_to_par_buffered;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic en = 1'b1, shift_en = 1'b0, clear = 1'b0, serial = 1'b0, ack = 1'b0;

    always #5 clk = ~clk;

    ser_to_par_buffered_if #(.WIDTH(8))  if_a ();
    ser_to_par_buffered_if #(.WIDTH(8))  if_b ();
    ser_to_par_buffered_if #(.WIDTH(12)) if_c ();

    assign if_a.en = en; assign if_a.shift_en = shift_en; assign if_a.clear = clear;
    assign if_a.serial = serial; assign if_a.ack = ack;
    assign if_b.en = en; assign if_b.shift_en = shift_en; assign if_b.clear = clear;
    assign if_b.serial = serial; assign if_b.ack = ack;
    assign if_c.en = en; assign if_c.shift_en = shift_en; assign if_c.clear = clear;
    assign if_c.serial = serial; assign if_c.ack = ack;

    ser_to_par_buffered #(.WIDTH(8),  .MSB_FIRST(1'b0)) u_a (.MHz10(clk), .nrst(nrst), .bus(if_a));
    ser_to_par_buffered #(.WIDTH(8),  .MSB_FIRST(1'b1)) u_b (.MHz10(clk), .nrst(nrst), .bus(if_b));
    ser_to_par_buffered #(.WIDTH(12), .MSB_FIRST(1'b0)) u_c (.MHz10(clk), .nrst(nrst), .bus(if_c));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: bit number i of a word goes to position i (LSB-first)
    // or WIDTH-1-i (MSB-first); the holder is a single slot with drop-on-full.
    localparam int MW[3] = '{8, 8, 12};
    localparam bit MM[3] = '{1'b0, 1'b1, 1'b0};
    int          m_cnt   [3];
    logic [31:0] m_acc   [3];
    logic [31:0] m_hold  [3];
    logic        m_valid [3];
    logic        m_ovr   [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0; m_acc[k] = '0; m_hold[k] = '0;
            m_valid[k] = 1'b0; m_ovr[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            bit          done;
            logic [31:0] w;
            int          pos;
            done = 1'b0;
            w    = '0;
            if (clear) begin
                m_cnt[k] = 0; m_acc[k] = '0; m_hold[k] = '0;
                m_valid[k] = 1'b0; m_ovr[k] = 1'b0;
            end else begin
                if (en && shift_en) begin
                    pos = MM[k] ? (MW[k] - 1 - m_cnt[k]) : m_cnt[k];
                    m_acc[k][pos] = serial;
                    m_cnt[k]++;
                    if (m_cnt[k] == MW[k]) begin
                        done = 1'b1;
                        w = m_acc[k];
                        m_cnt[k] = 0;
                    end
                end
                if (!m_valid[k]) begin
                    if (done) begin m_hold[k] = w; m_valid[k] = 1'b1; end
                end else if (done && ack) begin
                    m_hold[k] = w;
                end else if (done) begin
                    m_ovr[k] = 1'b1;
                end else if (ack) begin
                    m_valid[k] = 1'b0;
                end
            end
        end
    endtask

    always @(negedge nrst) model_reset();
    always @(posedge clk) if (nrst) model_step();

    always @(negedge clk) begin
        chk("a.par_out", if_a.par_out, m_hold[0]);
        chk("a.valid",   if_a.valid,   m_valid[0]);
        chk("a.overrun", if_a.overrun, m_ovr[0]);
        chk("a.bit_cnt", if_a.bit_cnt, m_cnt[0]);
        chk("b.par_out", if_b.par_out, m_hold[1]);
        chk("b.valid",   if_b.valid,   m_valid[1]);
        chk("b.overrun", if_b.overrun, m_ovr[1]);
        chk("b.bit_cnt", if_b.bit_cnt, m_cnt[1]);
        chk("c.par_out", if_c.par_out, m_hold[2]);
        chk("c.valid",   if_c.valid,   m_valid[2]);
        chk("c.overrun", if_c.overrun, m_ovr[2]);
        chk("c.bit_cnt", if_c.bit_cnt, m_cnt[2]);
    end

    task automatic cyc(input logic se, input logic b, input logic a, input logic c);
        @(negedge clk);
        shift_en = se; serial = b; ack = a; clear = c;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word8(input logic [7:0] v);
        for (int i = 0; i < 8; i++) cyc(1'b1, v[i], 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] w2;
        model_reset();
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_par_out", if_a.par_out, 8'h00);
        chk("rst_valid",   if_a.valid,   1'b0);
        chk("rst_overrun", if_a.overrun, 1'b0);
        chk("rst_bit_cnt", if_a.bit_cnt, 3'd0);
        nrst = 1'b1;
        idle();

        // Bits 1,0,1,1,0,0,1,0 with a strobe every 4 cycles.
        pat = 8'b0100_1101;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, pat[i], 1'b0, 1'b0);
            if (i < 7) repeat (3) idle();
        end
        idle();
        chk("lsb_par_out", if_a.par_out, 8'h4D);
        chk("lsb_valid",   if_a.valid,   1'b1);
        chk("lsb_bit_cnt", if_a.bit_cnt, 3'd0);
        chk("msb_par_out", if_b.par_out, 8'hB2);
        chk("model_pin_lsb", m_hold[0], 32'h4D);
        chk("model_pin_msb", m_hold[1], 32'hB2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("ack_drain_valid", if_a.valid, 1'b0);

        // Overrun: A5 held, 3C dropped.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        send_word8(8'hA5);
        idle();
        chk("hold_a5_par", if_a.par_out, 8'hA5);
        send_word8(8'h3C);
        idle();
        chk("ovr_par_kept", if_a.par_out, 8'hA5);
        chk("ovr_flag",     if_a.overrun, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("ovr_ack_valid",  if_a.valid,   1'b0);
        chk("ovr_sticky",     if_a.overrun, 1'b1);

        // ack coinciding with the completing sample of 3C.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        send_word8(8'hA5);
        w2 = 8'h3C;
        for (int i = 0; i < 8; i++) cyc(1'b1, w2[i], (i == 7), 1'b0);
        idle();
        chk("ackc_valid", if_a.valid,   1'b1);
        chk("ackc_par",   if_a.par_out, 8'h3C);
        chk("ackc_ovr",   if_a.overrun, 1'b0);

        // clear together with a strobe after 5 bits.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        idle();
        chk("clr_bit_cnt", if_a.bit_cnt, 3'd0);
        chk("clr_valid",   if_a.valid,   1'b0);
        send_word8(8'h5A);
        idle();
        chk("clr_clean_word", if_a.par_out, 8'h5A);

        // Asynchronous reset mid-word on the 12-bit instance.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        chk("w12_bit_cnt7", if_c.bit_cnt, 4'd7);
        #2 nrst = 1'b0;
        #1;
        chk("arst_c_bit_cnt", if_c.bit_cnt, 4'd0);
        chk("arst_c_valid",   if_c.valid,   1'b0);
        chk("arst_c_par",     if_c.par_out, 12'h000);
        chk("arst_c_ovr",     if_c.overrun, 1'b0);
        @(negedge clk);
        nrst = 1'b1;

        // en=0 blocks samples but ack still drains.
        send_word8(8'hC3);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        chk("en_pre_cnt",   if_a.bit_cnt, 3'd3);
        chk("en_pre_valid", if_a.valid,   1'b1);
        en = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        idle();
        chk("en_off_cnt", if_a.bit_cnt, 3'd3);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("en_off_drain", if_a.valid, 1'b0);
        en = 1'b1;

        // Randomised traffic.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            en       = ($urandom_range(0, 7) != 0);
            shift_en = 1'($urandom_range(0, 1));
            serial   = 1'($urandom_range(0, 1));
            ack      = ($urandom_range(0, 3) == 0);
            clear    = ($urandom_range(0, 299) == 0);
        end
        idle();
        repeat (3) idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
